fx3_tx_bridge: RTL

Downstream companion to `fsm_main`: accepts 23-bit words that `fsm_main` presents on `data_out`/`intr`, acknowledges each with a one-cycle `ack` pulse, buffers them in a small FIFO and streams them to the FX3 host interface as two 16-bit beats per word under `fx3_ready` back-pressure. It decouples `fsm_main` from FX3 stalls and provides level/count status for debug.

---
 rtl/fx3_tx_bridge.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fx3_tx_bridge.sv
// fx3_tx_bridge: acknowledges upstream words with a one-cycle ack, buffers them in a
// small FIFO and streams each word to the FX3 port as a low beat followed by a high beat.
module fx3_tx_bridge #(
    parameter int DATA_W = 23,
    parameter int DEPTH  = 8,
    parameter int LVL_W  = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              intr,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack,
    input  logic              flush,
    input  logic              fx3_ready,
    output logic              fx3_wr,
    output logic [15:0]       fx3_data,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [15:0]       tx_count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    // Upper word bits, right-aligned, with bit 15 marking the high beat.
    function automatic logic [15:0] high_beat(input logic [DATA_W-1:0] word);
        logic [15:0] res;
        res = 16'h8000 | 16'(word >> 16);
        return res;
    endfunction

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic               fx3_wr_q, fx3_wr_d;
    logic [15:0]        fx3_data_q, fx3_data_d;
    logic [15:0]        tx_count_q, tx_count_d;
    logic               ack_q, ack_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               beat_done_s;
    logic [DATA_W-1:0]  head_s;

    // Status decode from the pre-edge occupancy.
    always_comb begin
        full_s      = (level_q == LVL_W'(DEPTH));
        empty_s     = (level_q == {LVL_W{1'b0}});
        push_s      = intr & ~ack_q & ~full_s & ~flush;
        beat_done_s = fx3_wr_q & fx3_ready;
        head_s      = mem_q[rd_ptr_q];
    end

    // FIFO storage, pointers, occupancy and the upstream acknowledge.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ack_d    = push_s;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            level_d  = {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            level_d = level_q + LVL_W'(push_s) - LVL_W'(pop_s);
        end
    end

    // Output beat sequencer: pop a word, send low half, then high half.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        fx3_wr_d   = fx3_wr_q;
        fx3_data_d = fx3_data_q;
        tx_count_d = tx_count_q;
        pop_s      = 1'b0;
        if (flush) begin
            state_d    = ST_IDLE;
            fx3_wr_d   = 1'b0;
            fx3_data_d = 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        pop_s      = 1'b1;
                        word_d     = head_s;
                        fx3_wr_d   = 1'b1;
                        fx3_data_d = head_s[15:0];
                        state_d    = ST_LOW;
                    end else begin
                        fx3_wr_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (beat_done_s) begin
                        fx3_data_d = high_beat(word_q);
                        state_d    = ST_HIGH;
                    end else begin
                        fx3_data_d = word_q[15:0];
                        state_d    = ST_LOW;
                    end
                end
                ST_HIGH: begin
                    if (beat_done_s) begin
                        tx_count_d = tx_count_q + 16'd1;
                        if (!empty_s) begin
                            pop_s      = 1'b1;
                            word_d     = head_s;
                            fx3_wr_d   = 1'b1;
                            fx3_data_d = head_s[15:0];
                            state_d    = ST_LOW;
                        end else begin
                            fx3_wr_d = 1'b0;
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
                default: begin
                    fx3_wr_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= ST_IDLE;
            word_q     <= {DATA_W{1'b0}};
            fx3_wr_q   <= 1'b0;
            fx3_data_q <= 16'h0000;
            tx_count_q <= 16'h0000;
            ack_q      <= 1'b0;
            level_q    <= {LVL_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            mem_q      <= '{default: {DATA_W{1'b0}}};
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            fx3_wr_q   <= fx3_wr_d;
            fx3_data_q <= fx3_data_d;
            tx_count_q <= tx_count_d;
            ack_q      <= ack_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    assign ack        = ack_q;
    assign fx3_wr     = fx3_wr_q;
    assign fx3_data   = fx3_data_q;
    assign fifo_level = level_q;
    assign tx_count   = tx_count_q;

endmodule
